sipo_pack: RTL

SIPO_PACK -- requirements
Module: sipo_pack

---
 rtl/sipo_pack.sv | 59 +++++
 1 files changed

// File: rtl/sipo_pack.sv
// sipo_pack: packs WORD_W-bit words MSB-first into an N_WORDS-word block with a FILL/FULL handshake.
module sipo_pack #(
  parameter int WORD_W = 64,
  parameter int N_WORDS = 21,
  localparam int BLK_W = WORD_W * N_WORDS,
  localparam int CNT_W = $clog2(N_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WORD_W-1:0] data_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] data_out,
  output logic [CNT_W-1:0] out_words
);
  typedef enum logic {FILL, FULL} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BLK_W-1:0] data_q, data_d;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d = data_q;
    if (state_q == FULL) begin
      if (out_ready) begin
        state_d = FILL;
        count_d = '0;
        data_d = '0;
      end
    end else if (flush) begin
      count_d = '0;
      data_d = '0;
    end else if (in_valid) begin
      data_d[BLK_W-1-WORD_W*int'(count_q) -: WORD_W] = data_in;
      count_d = count_q + 1'b1;
      state_d = (in_last || count_q == CNT_W'(N_WORDS - 1)) ? FULL : FILL;
    end
  end
  // In FULL the count doubles as the number of valid words in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      count_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q <= data_d;
    end
  end
  assign in_ready = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign data_out = data_q;
  assign out_words = count_q;
endmodule
